conv3d_filter_sched: RTL and testbench
======================================

Name: conv3d_filter_sched

Overview:
- Sequencer for the 8-channel 3x3 conv3d filter datapath.
- For each of NUM_FILTERS output filters it does four things in order: clears the datapath, streams 73 weight words (72 weights + bias) from weight ROM, streams the WIDTH*HEIGHT feature map from image memory, and writes every convolution result into the output buffer.
- Sits between the layer-level control/memories and one conv3d filter instance.

Parameters:
- WIDTH, 8, input feature-map width.
- HEIGHT, 8, input feature-map height.
- CHANEL, 8, input channels; fixed at 8 by the datapath.
- NUM_FILTERS, 16, filters processed per start.
- ADDR_W, 16, width of all memory address ports.
- TIMEOUT, 1024, max cycles allowed in WAITK or DRAIN.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a layer run.
- busy  out  1  high from start accept until done.
- done  out  1  one-cycle pulse at end of layer.
- err  out  1  sticky timeout flag; cleared on start accept.
- wgt_addr  out  ADDR_W  weight ROM address; 1-cycle read latency.
- wgt_rdata  in  32  weight ROM data.
- img_addr  out  ADDR_W  pixel address; 8 channels read in parallel; 1-cycle latency.
- conv_resetn  out  1  datapath reset, active low.
- load_kernel  out  1  weight-word strobe to datapath.
- kernel  out  32  weight word to datapath (wgt_rdata passthrough).
- load_kernel_done  in  1  datapath has latched its bias.
- data_valid_in  out  1  pixel strobe to datapath.
- conv_valid_out  in  1  datapath result strobe.
- conv_data  in  32  datapath result (fp32).
- out_we  out  1  output buffer write enable.
- out_addr  out  ADDR_W  output buffer address.
- out_wdata  out  32  output buffer data.
- filter_idx  out  8  filter currently processed.

Behaviour:
- Constants:
  - KW = 9*CHANEL+1 = 73.
  - NPIX = WIDTH*HEIGHT.
  - NOUT = (WIDTH-2)*(HEIGHT-2).
- Reset (resetn low at a clk edge, any state, including mid-run):
  - state=IDLE.
  - All counters 0.
  - busy=0, done=0, err=0.
  - load_kernel=0, data_valid_in=0, out_we=0.
  - conv_resetn=0 (held low while resetn low).
  - All addresses 0, filter_idx=0.
- Weight layout: wgt_addr = filter_idx*KW + k. Words k=0..71 are channel-major (ch*9 + row*3 + col). Word k=72 is the bias.
- IDLE:
  - conv_resetn=1.
  - start -> CLR; busy=1, err=0, filter_idx=0.
  - start while busy is ignored.
- CLR: conv_resetn=0 for exactly 1 cycle -> LOADW. This clears the saturated kernel counter left by the previous filter.
- LOADW:
  - Issue wgt_addr for k=0..72, one per cycle.
  - load_kernel is the issue strobe delayed 1 cycle, aligned with wgt_rdata.
  - Exactly 73 load_kernel pulses, contiguous.
  - After the last issue -> WAITK.
- WAITK:
  - load_kernel_done=1 -> STREAM.
  - TIMEOUT cycles without it -> err=1, go to NEXT.
- STREAM:
  - img_addr = p for p=0..NPIX-1, one per cycle, raster order.
  - data_valid_in is the issue strobe delayed 1 cycle.
  - Exactly NPIX contiguous pulses.
  - Then -> DRAIN.
- Result capture (STREAM and DRAIN only):
  - Each conv_valid_out writes conv_data to out_addr = filter_idx*NOUT + ocnt, then ocnt++.
  - out_we/out_addr/out_wdata are registered: 1 cycle after conv_valid_out.
  - conv_valid_out in any other state is dropped. ocnt saturates at NOUT; extra results are dropped and set err.
- DRAIN:
  - ocnt==NOUT and no write pending -> NEXT.
  - TIMEOUT cycles -> err=1, go to NEXT.
- NEXT:
  - If filter_idx==NUM_FILTERS-1 -> DONE.
  - Else filter_idx++, ocnt=0, -> CLR.
- DONE: done=1 for 1 cycle, busy=0 -> IDLE.
- Cycle count per filter (no stalls) = 1 + 73 + 1 + WAITK + NPIX + drain. Back-to-back filters need no idle cycles beyond CLR.
- Address arithmetic:
  - Unsigned, ADDR_W wide, truncating.
  - Multiplies are implemented as running base registers (add KW / NOUT per filter), not multipliers.

Decomposition:
- Shared package conv_pkg holds:
  - KW, NOUT and NPIX as functions of the parameters.
  - State enum: IDLE, CLR, LOADW, WAITK, STREAM, DRAIN, NEXT, DONE.
  - The 32-bit fp word typedef.
- One sub-module, seq_issue: a counter plus 1-cycle-delayed strobe generator (count, base address, addr, valid_d1, last). It is instantiated twice, once for weights and once for pixels.

Test Plan:
- WIDTH=HEIGHT=8, NUM_FILTERS=2, behavioural datapath model, start pulse:
  - exactly 146 load_kernel pulses total, with conv_resetn low 1 cycle before each burst of 73;
  - wgt_addr ranges 0..72, then 73..145;
  - 72 outputs written to out_addr 0..71;
  - done pulses once; err=0.
- Kernel word check: ROM word k = k as fp32. Datapath model receives bias = 72.0 for filter 0 and 145.0 for filter 1, with no gaps within either load burst.
- Model never asserts load_kernel_done: err=1 after 1024 WAITK cycles, no data_valid_in pulses, run continues to the next filter, done still pulses.
- Model emits only 35 results for a filter: DRAIN times out, err=1, out_addr of the next filter starts at 36.
- resetn low for 1 cycle mid-STREAM (pixel 20): the next cycle has busy=0, data_valid_in=0, conv_resetn=0. A new start then reruns from filter 0, wgt_addr 0.
- start pulsed again while busy, and conv_valid_out asserted in IDLE: both ignored, no out_we, filter_idx unaffected.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and derived sizes for the conv3d filter sequencer and its issue counters.
package conv_pkg;

    typedef logic [31:0] fp32_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        LOADW  = 3'd2,
        WAITK  = 3'd3,
        STREAM = 3'd4,
        DRAIN  = 3'd5,
        NEXT   = 3'd6,
        DONE   = 3'd7
    } state_t;

    // 72 channel-major weights followed by one bias word
    function automatic int kw_f(input int chanel);
        return 9 * chanel + 1;
    endfunction

    function automatic int npix_f(input int width, input int height);
        return width * height;
    endfunction

    function automatic int nout_f(input int width, input int height);
        return (width - 2) * (height - 2);
    endfunction

endpackage

// File: rtl/seq_issue.sv
// Linear address issuer: emits len consecutive addresses from base, one per cycle,
// with a strobe delayed one cycle to line up with 1-cycle-latency memory data.
module seq_issue #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] addr,
    output logic              valid_d1,
    output logic              last
);

    logic [ADDR_W-1:0] count_r;
    logic              active_r;

    assign last = active_r && (count_r == len - ADDR_W'(1));

    // Issue counter, address register and delayed strobe
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_r  <= '0;
            addr     <= '0;
            active_r <= 1'b0;
            valid_d1 <= 1'b0;
        end else begin
            valid_d1 <= active_r;
            if (start) begin
                active_r <= 1'b1;
                count_r  <= '0;
                addr     <= base;
            end else if (last) begin
                active_r <= 1'b0;
            end else if (active_r) begin
                count_r <= count_r + ADDR_W'(1);
                addr    <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv3d_filter_sched.sv
// Per-filter sequencer for the 8-channel 3x3 conv3d datapath: clear, load kernel,
// stream the feature map and capture every result into the output buffer.
module conv3d_filter_sched
    import conv_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HEIGHT      = 8,
    parameter int CHANEL      = 8,
    parameter int NUM_FILTERS = 16,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] wgt_addr,
    input  logic [31:0]       wgt_rdata,
    output logic [ADDR_W-1:0] img_addr,
    output logic              conv_resetn,
    output logic              load_kernel,
    output logic [31:0]       kernel,
    input  logic              load_kernel_done,
    output logic              data_valid_in,
    input  logic              conv_valid_out,
    input  logic [31:0]       conv_data,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_wdata,
    output logic [7:0]        filter_idx
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [ADDR_W-1:0] KW_A   = ADDR_W'(kw_f(CHANEL));
    localparam logic [ADDR_W-1:0] NPIX_A = ADDR_W'(npix_f(WIDTH, HEIGHT));
    localparam logic [ADDR_W-1:0] NOUT_A = ADDR_W'(nout_f(WIDTH, HEIGHT));

    state_t            state_r, state_nx_s;
    logic [TW-1:0]     tmr_r;
    logic [7:0]        fidx_r;
    logic [ADDR_W-1:0] wbase_r, obase_r, ocnt_r, oaddr_r;
    fp32_t             wdata_r;
    logic              busy_r, done_r, err_r, crst_r, we_r;
    logic              w_last_s, p_last_s, tmo_s, tmo_err_s, accept_s;
    logic              last_filter_s, drained_s, capt_s, drop_s;

    assign accept_s      = (state_r == IDLE) && start;
    assign tmo_s         = (tmr_r == TW'(TIMEOUT - 1));
    assign last_filter_s = (fidx_r == 8'(NUM_FILTERS - 1));
    assign drained_s     = (ocnt_r == NOUT_A) && !we_r;
    assign capt_s        = conv_valid_out && ((state_r == STREAM) || (state_r == DRAIN));
    assign drop_s        = capt_s && (ocnt_r == NOUT_A);

    seq_issue #(.ADDR_W(ADDR_W)) u_wgt (
        .clk      (clk),
        .resetn   (resetn),
        .start    (state_r == CLR),
        .base     (wbase_r),
        .len      (KW_A),
        .addr     (wgt_addr),
        .valid_d1 (load_kernel),
        .last     (w_last_s)
    );

    seq_issue #(.ADDR_W(ADDR_W)) u_pix (
        .clk      (clk),
        .resetn   (resetn),
        .start    ((state_r == WAITK) && load_kernel_done),
        .base     ({ADDR_W{1'b0}}),
        .len      (NPIX_A),
        .addr     (img_addr),
        .valid_d1 (data_valid_in),
        .last     (p_last_s)
    );

    // Next-state decode; timeouts abandon the filter and flag the error
    always_comb begin
        state_nx_s = state_r;
        tmo_err_s  = 1'b0;
        case (state_r)
            IDLE:   if (start) state_nx_s = CLR; else state_nx_s = IDLE;
            CLR:    state_nx_s = LOADW;
            LOADW:  if (w_last_s) state_nx_s = WAITK; else state_nx_s = LOADW;
            WAITK: begin
                if (load_kernel_done) begin
                    state_nx_s = STREAM;
                end else if (tmo_s) begin
                    state_nx_s = NEXT;
                    tmo_err_s  = 1'b1;
                end else begin
                    state_nx_s = WAITK;
                end
            end
            STREAM: if (p_last_s) state_nx_s = DRAIN; else state_nx_s = STREAM;
            DRAIN: begin
                if (drained_s) begin
                    state_nx_s = NEXT;
                end else if (tmo_s) begin
                    state_nx_s = NEXT;
                    tmo_err_s  = 1'b1;
                end else begin
                    state_nx_s = DRAIN;
                end
            end
            NEXT:    if (last_filter_s) state_nx_s = DONE; else state_nx_s = CLR;
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register, registered status strobes and per-state timer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            crst_r  <= 1'b0;
            tmr_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= !((state_nx_s == IDLE) || (state_nx_s == DONE));
            done_r  <= (state_nx_s == DONE);
            crst_r  <= (state_nx_s != CLR);
            tmr_r   <= (state_nx_s != state_r) ? TW'(0) : tmr_r + TW'(1);
        end
    end

    // Filter index and running base addresses replace filter_idx*KW / filter_idx*NOUT
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fidx_r  <= 8'd0;
            wbase_r <= '0;
            obase_r <= '0;
        end else if (accept_s) begin
            fidx_r  <= 8'd0;
            wbase_r <= '0;
            obase_r <= '0;
        end else if ((state_r == NEXT) && !last_filter_s) begin
            fidx_r  <= fidx_r + 8'd1;
            wbase_r <= wbase_r + KW_A;
            obase_r <= obase_r + NOUT_A;
        end
    end

    // Result capture into the output buffer plus the sticky error flag
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ocnt_r  <= '0;
            we_r    <= 1'b0;
            oaddr_r <= '0;
            wdata_r <= '0;
            err_r   <= 1'b0;
        end else begin
            if (capt_s && !drop_s) begin
                we_r    <= 1'b1;
                oaddr_r <= obase_r + ocnt_r;
                wdata_r <= conv_data;
            end else begin
                we_r <= 1'b0;
            end
            if (accept_s || ((state_r == NEXT) && !last_filter_s)) begin
                ocnt_r <= '0;
            end else if (capt_s && !drop_s) begin
                ocnt_r <= ocnt_r + ADDR_W'(1);
            end
            if (accept_s) begin
                err_r <= 1'b0;
            end else if (tmo_err_s || drop_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign conv_resetn = crst_r;
    assign kernel      = wgt_rdata;
    assign out_we      = we_r;
    assign out_addr    = oaddr_r;
    assign out_wdata   = wdata_r;
    assign filter_idx  = fidx_r;

endmodule

// File: tb/tb_conv3d_filter_sched.sv
// Self-checking bench: behavioural conv datapath + weight ROM model, scenario table, corner sequences.
module tb_conv3d_filter_sched;

    localparam int NF = 2;

    logic        clk = 1'b0, resetn = 1'b0, start = 1'b0;
    logic        busy, done, err, conv_resetn, load_kernel, data_valid_in, out_we;
    logic [15:0] wgt_addr, img_addr, out_addr;
    logic [31:0] kernel, out_wdata, wgt_rdata = 32'h0, conv_data = 32'h0;
    logic [7:0]  filter_idx;
    logic        load_kernel_done = 1'b0, conv_valid_out = 1'b0;

    always #5 clk = ~clk;

    conv3d_filter_sched #(.WIDTH(8), .HEIGHT(8), .CHANEL(8), .NUM_FILTERS(NF),
                          .ADDR_W(16), .TIMEOUT(1024)) dut (
        .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done), .err(err),
        .wgt_addr(wgt_addr), .wgt_rdata(wgt_rdata), .img_addr(img_addr),
        .conv_resetn(conv_resetn), .load_kernel(load_kernel), .kernel(kernel),
        .load_kernel_done(load_kernel_done), .data_valid_in(data_valid_in),
        .conv_valid_out(conv_valid_out), .conv_data(conv_data), .out_we(out_we),
        .out_addr(out_addr), .out_wdata(out_wdata), .filter_idx(filter_idx)
    );

    int errors = 0, checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] int_to_fp32(input int n);
        int e;
        logic [31:0] m;
        if (n <= 0) return 32'h0;
        e = 0;
        for (int i = 0; i < 31; i++) if ((n >> i) != 0) e = i;
        m = 32'(n) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    typedef struct { int due; logic [31:0] data; } res_t;
    typedef struct { logic [15:0] addr; logic [31:0] data; } wr_t;
    typedef struct { bit lkd_en; int nres0; int extra_at;
                     bit exp_err; int exp_lk; int exp_dv; int exp_wr; } vec_t;

    // Scenario configuration and per-run observation state
    bit          cfg_lkd_en = 1'b1, inject_cvo = 1'b0, mute = 1'b0;
    int          cfg_nres0 = 36, cfg_lat = 1, cfg_lkd_dly = 0;
    logic [31:0] salt = 32'h0;
    int          cyc = 0, last_clr = 0;
    int          lk_total = 0, lk_run = 0, dv_total = 0, dv_run = 0, wr_total = 0, done_cnt = 0;
    logic [15:0] prev_wgt_addr = 16'h0, prev_img_addr = 16'h0;
    int          kcnt = 0, lkd_cnt = 0, pix = 0, nres_this = 0;
    logic [31:0] bias_cur = 32'h0;
    res_t        rq[$];
    wr_t         exp_q[$];

    // Monitor + datapath/ROM model, evaluated mid-cycle away from the clock edge
    always @(negedge clk) begin
        cyc++;
        if (load_kernel) begin
            check("wgt_addr_seq", prev_wgt_addr, lk_total);
            check("filter_idx_load", filter_idx, lk_total / 73);
            check("kernel_word", kernel, int_to_fp32(lk_total));
            if (lk_run == 0) check("clr_before_burst", (cyc - last_clr) <= 2, 1);
            if (lk_run == 72) check("bias", kernel, (lk_total < 73) ? 32'h42900000 : 32'h43110000);
            lk_total++;
            lk_run++;
        end else if (lk_run != 0) begin
            if (!mute) check("lk_burst_len", lk_run, 73);
            lk_run = 0;
        end
        if (data_valid_in) begin
            check("img_addr_seq", prev_img_addr, dv_run);
            dv_total++;
            dv_run++;
        end else if (dv_run != 0) begin
            if (!mute) check("dv_burst_len", dv_run, 64);
            dv_run = 0;
        end
        if (out_we) begin
            wr_total++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                check("out_addr", out_addr, exp_q[0].addr);
                check("out_wdata", out_wdata, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
        if (done) begin
            done_cnt++;
            check("busy_at_done", busy, 0);
        end

        // datapath model
        if (!conv_resetn) begin
            kcnt = 0; lkd_cnt = 0; pix = 0; nres_this = 0;
            rq.delete();
            load_kernel_done = 1'b0;
            last_clr = cyc;
        end else begin
            if (load_kernel) begin
                if (kcnt == 72) bias_cur = kernel;
                kcnt++;
            end
            if (kcnt >= 73 && cfg_lkd_en) begin
                if (lkd_cnt >= cfg_lkd_dly) load_kernel_done = 1'b1;
                else lkd_cnt++;
            end
            if (data_valid_in) begin
                if ((pix / 8) >= 2 && (pix % 8) >= 2 &&
                    nres_this < ((lk_total > 73) ? 36 : cfg_nres0)) begin
                    rq.push_back('{cyc + cfg_lat, bias_cur ^ 32'(pix) ^ salt});
                    nres_this++;
                end
                pix++;
            end
        end
        conv_valid_out = 1'b0;
        if (rq.size() != 0 && rq[0].due <= cyc) begin
            conv_valid_out = 1'b1;
            conv_data = rq[0].data;
            void'(rq.pop_front());
        end
        if (inject_cvo) begin
            conv_valid_out = 1'b1;
            conv_data = 32'hDEADBEEF;
        end
        wgt_rdata     = int_to_fp32(int'(wgt_addr));
        prev_wgt_addr = wgt_addr;
        prev_img_addr = img_addr;
    end

    task automatic setup_run(input vec_t v);
        int p, n;
        cfg_lkd_en  = v.lkd_en;
        cfg_nres0   = v.nres0;
        cfg_lat     = int'($urandom_range(1, 4));
        cfg_lkd_dly = int'($urandom_range(0, 3));
        salt        = $urandom;
        lk_total = 0; lk_run = 0; dv_total = 0; dv_run = 0; wr_total = 0; done_cnt = 0;
        mute = 1'b0;
        exp_q.delete();
        for (int f = 0; f < NF; f++) begin
            n = !v.lkd_en ? 0 : (f == 0) ? v.nres0 : 36;
            for (int j = 0; j < n; j++) begin
                p = (2 + j / 6) * 8 + 2 + j % 6;
                exp_q.push_back('{16'(f * 36 + j),
                    ((f == 0) ? 32'h42900000 : 32'h43110000) ^ 32'(p) ^ salt});
            end
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        int n;
        setup_run(v);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 8000) begin
            @(negedge clk);
            n++;
            start = (v.extra_at != 0 && n == v.extra_at);
        end
        start = 1'b0;
        check("done_seen", done_cnt > 0, 1);
        repeat (5) @(negedge clk);
        $display("row %0d: lk=%0d dv=%0d wr=%0d err=%0b", idx, lk_total, dv_total, wr_total, err);
        check("done_once", done_cnt, 1);
        check("err_final", err, v.exp_err);
        check("lk_total", lk_total, v.exp_lk);
        check("dv_total", dv_total, v.exp_dv);
        check("wr_total", wr_total, v.exp_wr);
        check("exp_q_empty", exp_q.size(), 0);
        check("busy_idle", busy, 0);
    endtask

    vec_t tbl[4];

    initial begin
        int n;
        tbl[0] = '{1'b1, 36, 0,  1'b0, 146, 128, 72};
        tbl[1] = '{1'b0, 36, 0,  1'b1, 146, 0,   0};
        tbl[2] = '{1'b1, 35, 0,  1'b1, 146, 128, 71};
        tbl[3] = '{1'b1, 36, 40, 1'b0, 146, 128, 72};

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_conv_resetn", conv_resetn, 0);
        check("rst_load_kernel", load_kernel, 0);
        check("rst_dv", data_valid_in, 0);
        check("rst_out_we", out_we, 0);
        check("rst_addrs", {wgt_addr, img_addr, out_addr}, 48'h0);
        check("rst_filter_idx", filter_idx, 0);
        resetn = 1'b1;
        @(negedge clk);
        check("idle_conv_resetn", conv_resetn, 1);

        for (int i = 0; i < 4; i++) run(tbl[i], i);

        // results arriving in IDLE are dropped and leave filter_idx alone
        wr_total = 0;
        inject_cvo = 1'b1;
        repeat (5) @(negedge clk);
        inject_cvo = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_cvo_writes", wr_total, 0);
        check("idle_filter_idx", filter_idx, NF - 1);
        check("idle_busy", busy, 0);

        // reset in the middle of streaming, then a clean rerun
        setup_run(tbl[0]);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (dv_total < 20 && n < 3000) begin @(negedge clk); n++; end
        check("reached_pixel20", dv_total >= 20, 1);
        mute = 1'b1;
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_dv", data_valid_in, 0);
        check("midrst_conv_resetn", conv_resetn, 0);
        check("midrst_out_we", out_we, 0);
        check("midrst_filter_idx", filter_idx, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        run(tbl[0], 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
